// File: rtl/vga_scan_controller.sv
// VGA scan controller.
// Generates 640x480@60Hz sync timing from the system clock, scans a 128x96
// vram image upscaled by SCALE in both axes, and registers the returned colour
// so that sync and RGB leave the block aligned, one pixel behind the counters.
module vga_scan_controller #(
  parameter int unsigned CLK_DIV = 4,    // system clocks per pixel, >= 2
  parameter int unsigned H_VIS   = 640,
  parameter int unsigned H_FP    = 16,
  parameter int unsigned H_SYNC  = 96,
  parameter int unsigned H_BP    = 48,
  parameter int unsigned V_VIS   = 480,
  parameter int unsigned V_FP    = 10,
  parameter int unsigned V_SYNC  = 2,
  parameter int unsigned V_BP    = 33,
  parameter int unsigned SCALE   = 5     // screen pixels per vram texel
) (
  input  logic        clk,
  input  logic        reset,      // asynchronous, active-low
  input  logic        enable,
  output logic        vram_en,
  output logic [13:0] vram_addr,
  input  logic [2:0]  vram_data,
  output logic        hsync,
  output logic        vsync,
  output logic        vga_r,
  output logic        vga_g,
  output logic        vga_b
);

  localparam int unsigned H_TOTAL  = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_FIRST = H_VIS + H_FP;
  localparam int unsigned HS_LAST  = HS_FIRST + H_SYNC - 1;
  localparam int unsigned VS_FIRST = V_VIS + V_FP;
  localparam int unsigned VS_LAST  = VS_FIRST + V_SYNC - 1;
  localparam int unsigned DIV_W    = $clog2(CLK_DIV);
  localparam int unsigned H_W      = $clog2(H_TOTAL);
  localparam int unsigned V_W      = $clog2(V_TOTAL);
  localparam int unsigned SUB_W    = (SCALE > 1) ? $clog2(SCALE) : 1;

  // Everything that describes where the beam is, advanced together on a tick.
  typedef struct packed {
    logic [H_W-1:0]   hcount;
    logic [V_W-1:0]   vcount;
    logic [SUB_W-1:0] hsub;
    logic [SUB_W-1:0] vsub;
    logic [6:0]       col;
    logic [6:0]       row;
  } scan_t;

  logic [DIV_W-1:0] div_q, div_d;
  scan_t            scan_q, scan_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic [2:0]       rgb_q, rgb_d;
  logic             tick;

  // Texel coordinates stop at the last vram column/row instead of wrapping.
  function automatic logic [6:0] sat_inc(input logic [6:0] v);
    return (v == 7'd127) ? v : v + 7'd1;
  endfunction

  assign tick = enable && (div_q == DIV_W'(CLK_DIV - 1));

  // Next divider and scan position: one pixel per tick, wrapping line then frame.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
    div_d  = div_q;
    scan_d = scan_q;
    if (enable) begin
      div_d = tick ? '0 : div_q + DIV_W'(1);
    end
    if (tick) begin
      if (scan_q.hcount == H_W'(H_TOTAL - 1)) begin
        scan_d.hcount = '0;
        scan_d.hsub   = '0;
        scan_d.col    = '0;
        if (scan_q.vcount == V_W'(V_TOTAL - 1)) begin
          scan_d.vcount = '0;
          scan_d.vsub   = '0;
          scan_d.row    = '0;
        end else begin
          scan_d.vcount = scan_q.vcount + V_W'(1);
          if (scan_q.vsub == SUB_W'(SCALE - 1)) begin
            scan_d.vsub = '0;
            scan_d.row  = sat_inc(scan_q.row);
          end else begin
            scan_d.vsub = scan_q.vsub + SUB_W'(1);
          end
        end
      end else begin
        scan_d.hcount = scan_q.hcount + H_W'(1);
        if (scan_q.hsub == SUB_W'(SCALE - 1)) begin
          scan_d.hsub = '0;
          scan_d.col  = sat_inc(scan_q.col);
        end else begin
          scan_d.hsub = scan_q.hsub + SUB_W'(1);
        end
      end
    end
  end

  // Output stage: decode the pixel being left on this tick, blank while disabled.
  always_comb begin
    hsync_d = hsync_q;
    vsync_d = vsync_q;
    rgb_d   = rgb_q;
    if (!enable) begin
      hsync_d = 1'b1;
      vsync_d = 1'b1;
      rgb_d   = 3'b000;
    end else if (tick) begin
      hsync_d = !((scan_q.hcount >= H_W'(HS_FIRST)) && (scan_q.hcount <= H_W'(HS_LAST)));
      vsync_d = !((scan_q.vcount >= V_W'(VS_FIRST)) && (scan_q.vcount <= V_W'(VS_LAST)));
      rgb_d   = ((scan_q.hcount < H_W'(H_VIS)) && (scan_q.vcount < V_W'(V_VIS)))
                ? vram_data : 3'b000;
    end
  end

  // State registers; reset parks the beam at (0,0) with syncs idle-high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_q   <= '0;
      scan_q  <= '0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      rgb_q   <= 3'b000;
    end else begin
      // NOTE: non-blocking assignments let every register sample the pre-edge values, whatever the statement order.
      div_q   <= div_d;
      scan_q  <= scan_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      rgb_q   <= rgb_d;
    end
  end

  // Disable blanks the pins at once rather than on the next clock edge.
  assign vram_en   = enable & reset;
  assign vram_addr = {scan_q.row, scan_q.col};
  assign hsync     = hsync_q | ~enable;
  assign vsync     = vsync_q | ~enable;
  assign {vga_r, vga_g, vga_b} = rgb_q & {3{enable}};

endmodule

// File: tb/tb_vga_scan_controller.sv
// Bench for vga_scan_controller. Full horizontal timing, CLK_DIV=2 and a short
// frame (16 lines) so that frame wrap and vsync fit in a short run.
module tb_vga_scan_controller;

  localparam int CLK_DIV = 2;
  localparam int H_VIS = 640, H_FP = 16, H_SYNC = 96, H_BP = 48;
  localparam int V_VIS = 12,  V_FP = 1,  V_SYNC = 2,  V_BP = 1;
  localparam int SCALE = 5;
  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;   // 800
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;   // 16
  localparam int FRAME = H_TOT * V_TOT;                  // pixels per frame

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        vram_en;
  logic [13:0] vram_addr;
  logic [2:0]  vram_data = 3'b000;
  logic        hsync, vsync, vga_r, vga_g, vga_b;

  int n_checks = 0;
  int n_errors = 0;

  vga_scan_controller #(
    .CLK_DIV(CLK_DIV), .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP), .SCALE(SCALE)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .vram_en(vram_en), .vram_addr(vram_addr), .vram_data(vram_data),
    .hsync(hsync), .vsync(vsync), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b)
  );

  initial forever #5 clk = ~clk;

  // vram stub colours: row 1 is a red stripe, row 2 is white, other rows vary by column.
  function automatic logic [2:0] color_of(input int row, input int col);
    if (row == 1) return 3'b100;
    if (row == 2) return 3'b111;
    return 3'((row + col + 1) % 8);
  endfunction

  // vram stub with one clock of read latency.
  always @(posedge clk) vram_data <= color_of(int'(vram_addr[13:7]), int'(vram_addr[6:0]));

  // Reference model: number of pixel ticks since reset and clocks into the current pixel.
  int div_m = 0;
  int n_m = 0;
  bit out_valid_m = 1'b0;
  int edges = 0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_m <= 0;
      n_m <= 0;
      out_valid_m <= 1'b0;
    end else if (!enable) begin
      out_valid_m <= 1'b0;
    end else if (div_m == CLK_DIV - 1) begin
      div_m <= 0;
      n_m <= n_m + 1;
      out_valid_m <= 1'b1;
    end else begin
      div_m <= div_m + 1;
    end
  end

  always @(posedge clk or negedge reset) begin
    if (!reset) edges <= 0;
    else edges <= edges + 1;
  end

  function automatic logic [13:0] addr_at(input int n);
    int q, col, row;
    q = n % FRAME;
    col = (q % H_TOT) / SCALE;
    row = (q / H_TOT) / SCALE;
    if (col > 127) col = 127;
    if (row > 127) row = 127;
    return {7'(row), 7'(col)};
  endfunction

  // Expected {vram_en, vram_addr, hsync, vsync, r, g, b}.
  function automatic logic [19:0] model_out();
    logic [13:0] a, pa;
    logic hs, vs;
    logic [2:0] rgb;
    int q, h, v;
    if (!reset) return {1'b0, 14'd0, 1'b1, 1'b1, 3'b000};
    a = addr_at(n_m);
    hs = 1'b1;
    vs = 1'b1;
    rgb = 3'b000;
    if (enable && out_valid_m) begin
      q = (n_m - 1) % FRAME;
      h = q % H_TOT;
      v = q / H_TOT;
      hs = !(h >= H_VIS + H_FP && h < H_VIS + H_FP + H_SYNC);
      vs = !(v >= V_VIS + V_FP && v < V_VIS + V_FP + V_SYNC);
      if (h < H_VIS && v < V_VIS) begin
        pa = addr_at(n_m - 1);
        rgb = color_of(int'(pa[13:7]), int'(pa[6:0]));
      end
    end
    return {enable, a, hs, vs, rgb};
  endfunction

  function automatic logic [19:0] dut_out();
    return {vram_en, vram_addr, hsync, vsync, vga_r, vga_g, vga_b};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      check("scan_outputs", 32'(dut_out()), 32'(model_out()));
    end
  end

  function automatic int probe(input int sel);
    case (sel)
      0: return int'(vga_b);
      1: return int'(hsync);
      2: return int'(vsync);
      3: return int'(vram_addr[6:0]);
      default: return int'(vram_addr);
    endcase
  endfunction

  // Edge count since reset release at which the probed signal first equals target (-1 on timeout).
  task automatic count_until(input int sel, input int target, input int limit, output int t);
    t = -1;
    for (int i = 0; i < limit; i++) begin
      @(posedge clk);
      #2;
      if (probe(sel) == target) begin
        t = edges;
        break;
      end
    end
  endtask

  // Wait until the pins show screen pixel (v,h); counts a failed comparison on timeout.
  task automatic wait_pos(input string name, input int v, input int h, input int limit);
    bit found;
    found = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(posedge clk);
      #2;
      if (out_valid_m && ((n_m - 1) % FRAME == v * H_TOT + h)) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: pixel (%0d,%0d) not reached within %0d clocks", name, v, h, limit);
    end
  endtask

  int t, t0;

  initial begin
    #1 reset = 1'b0;
    enable = 1'b1;
    #11;
    check("reset_state", 32'(dut_out()), 32'({1'b0, 14'd0, 1'b1, 1'b1, 3'b000}));
    @(negedge clk);
    reset = 1'b1;

    // First tick on the CLK_DIV-th edge shows pixel (0,0), colour 001.
    count_until(0, 1, 20, t);
    check("first_tick_edge", 32'(t), 32'd2);
    // Column steps to 1 at hcount 5 and saturates at 127 from hcount 635.
    count_until(3, 1, 100, t);
    check("col1_edge", 32'(t), 32'd10);
    count_until(3, 127, 2000, t);
    check("col127_edge", 32'(t), 32'd1270);
    // hsync: first fall at (656+1) ticks, 96 pixels low, 800-pixel period.
    count_until(1, 0, 2000, t);
    check("hsync_first_fall", 32'(t), 32'd1314);
    t0 = t;
    count_until(1, 1, 2000, t);
    check("hsync_low_width", 32'(t - t0), 32'd192);
    count_until(1, 0, 4000, t);
    check("hsync_period", 32'(t - t0), 32'd1600);

    // Colour by row and column, and blanking outside the visible area.
    wait_pos("pos_3_100", 3, 100, 20000);
    check("rgb_row0_col20", 32'({vga_r, vga_g, vga_b}), 32'd5);
    wait_pos("pos_7_100", 7, 100, 20000);
    check("rgb_red_stripe", 32'({vga_r, vga_g, vga_b}), 32'b100);
    wait_pos("pos_10_100", 10, 100, 20000);
    check("rgb_white_row", 32'({vga_r, vga_g, vga_b}), 32'b111);
    wait_pos("pos_10_700", 10, 700, 4000);
    check("rgb_blank_hporch", 32'({vga_r, vga_g, vga_b}), 32'b000);
    check("hsync_low_at_700", 32'(hsync), 32'd0);

    // Enable gap right after the tick into hcount 300 on line 11.
    t = 0;
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk);
      #2;
      if (out_valid_m && div_m == 0 && (n_m % H_TOT) == 300) begin
        t = 1;
        break;
      end
    end
    check("gap_start_found", 32'(t), 32'd1);
    @(negedge clk);
    enable = 1'b0;
    #1;
    check("gap_blank", 32'({vram_en, hsync, vsync, vga_r, vga_g, vga_b}), 32'b011000);
    repeat (50) @(posedge clk);
    #2;
    check("gap_addr_held", 32'(vram_addr), 32'd316);   // {row 2, col 60}
    @(negedge clk);
    enable = 1'b1;
    t0 = edges;
    // Resume at hcount 301: hsync falls after 357 more ticks.
    count_until(1, 0, 2000, t);
    check("hsync_after_gap", 32'(t - t0), 32'd714);

    // Asynchronous reset between edges while hsync is low mid-frame.
    wait_pos("pos_11_700", 11, 700, 4000);
    @(negedge clk);
    #1 reset = 1'b0;
    #1;
    check("async_reset_now", 32'(dut_out()), 32'({1'b0, 14'd0, 1'b1, 1'b1, 3'b000}));
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    count_until(4, 1, 100, t);
    check("restart_col1_edge", 32'(t), 32'd10);

    // vsync: low on lines 13-14, two lines wide, one frame period.
    count_until(2, 0, 30000, t);
    check("vsync_first_fall", 32'(t), 32'd20802);
    t0 = t;
    count_until(2, 1, 10000, t);
    check("vsync_low_width", 32'(t - t0), 32'd3200);
    count_until(2, 0, 30000, t);
    check("vsync_period", 32'(t - t0), 32'd25600);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
